// File: rtl/decode_queue.sv
// Instruction buffer between fetch and dispatch: a small FIFO whose head is
// decoded (RV32I) and dispatched to LSB/RS/ROB through a one-cycle output stage.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             in_isjump,
  input  logic [31:0]      in_wrong_pc,
  input  logic             rob_full,
  input  logic             lsb_full,
  input  logic             rs_full,
  output logic [4:0]       reg_rs1,
  output logic [4:0]       reg_rs2,
  input  logic             rf_rs1_ready,
  input  logic             rf_rs2_ready,
  input  logic [31:0]      rf_reg1,
  input  logic [31:0]      rf_reg2,
  input  logic             rob_rs1_ready,
  input  logic             rob_rs2_ready,
  input  logic [31:0]      rob_reg1,
  input  logic [31:0]      rob_reg2,
  output logic             out_valid,
  output logic [4:0]       rd,
  output logic [5:0]       opcode_id,
  output logic [31:0]      imm,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [31:0]      reg1,
  output logic [31:0]      reg2,
  output logic             to_lsb,
  output logic             to_rs,
  output logic             illegal,
  output logic             out_isjump,
  output logic [31:0]      out_wrong_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [5:0] {
    ID_NONE, ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
    ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
    ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
    ID_SB, ID_SH, ID_SW,
    ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI,
    ID_SLLI, ID_SRLI, ID_SRAI,
    ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND
  } opid_e;

  logic [31:0]      r_instr  [DEPTH];
  logic             r_isjump [DEPTH];
  logic [31:0]      r_wpc    [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  logic        r_out_valid, r_to_lsb, r_to_rs, r_illegal, r_out_isjump;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [5:0]  r_opcode_id;
  logic [31:0] r_imm, r_out_wrong_pc;

  logic        w_full, w_empty, w_push, w_pop;
  logic [31:0] w_ins;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_f7b;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
  opid_e       w_id;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_imm;
  logic        w_lsb, w_rs, w_ill;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !rst && rdy && !w_full && !flush;
  assign w_push   = in_valid && in_ready;

  assign w_ins    = r_instr[r_head];
  assign w_op     = w_ins[6:0];
  assign w_f3     = w_ins[14:12];
  assign w_f7b    = w_ins[30];
  assign w_imm_i  = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b  = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u  = {w_ins[31:12], 12'h000};
  assign w_imm_j  = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
  assign w_imm_sh = {27'd0, w_ins[24:20]};

  always_comb begin
    w_id  = ID_NONE;
    w_rd  = w_ins[11:7];
    w_rs1 = w_ins[19:15];
    w_rs2 = '0;
    w_imm = '0;
    w_lsb = 1'b0;
    w_rs  = 1'b0;
    case (w_op)
      7'b0110111: begin w_id = ID_LUI;   w_rs1 = '0; w_imm = w_imm_u; end
      7'b0010111: begin w_id = ID_AUIPC; w_rs1 = '0; w_imm = w_imm_u; end
      7'b1101111: begin w_id = ID_JAL;   w_rs1 = '0; w_imm = w_imm_j; end
      7'b1100111: begin
        if (w_f3 == 3'd0) w_id = ID_JALR;
        w_imm = w_imm_i;
        w_rs  = 1'b1;
      end
      7'b1100011: begin
        case (w_f3)
          3'd0: w_id = ID_BEQ;
          3'd1: w_id = ID_BNE;
          3'd4: w_id = ID_BLT;
          3'd5: w_id = ID_BGE;
          3'd6: w_id = ID_BLTU;
          3'd7: w_id = ID_BGEU;
          default: w_id = ID_NONE;
        endcase
        w_rd  = '0;
        w_rs2 = w_ins[24:20];
        w_imm = w_imm_b;
        w_rs  = 1'b1;
      end
      7'b0000011: begin
        case (w_f3)
          3'd0: w_id = ID_LB;
          3'd1: w_id = ID_LH;
          3'd2: w_id = ID_LW;
          3'd4: w_id = ID_LBU;
          3'd5: w_id = ID_LHU;
          default: w_id = ID_NONE;
        endcase
        w_imm = w_imm_i;
        w_lsb = 1'b1;
      end
      7'b0100011: begin
        case (w_f3)
          3'd0: w_id = ID_SB;
          3'd1: w_id = ID_SH;
          3'd2: w_id = ID_SW;
          default: w_id = ID_NONE;
        endcase
        w_rd  = '0;
        w_rs2 = w_ins[24:20];
        w_imm = w_imm_s;
        w_lsb = 1'b1;
      end
      7'b0010011: begin
        case (w_f3)
          3'd0: w_id = ID_ADDI;
          3'd1: w_id = ID_SLLI;
          3'd2: w_id = ID_SLTI;
          3'd3: w_id = ID_SLTIU;
          3'd4: w_id = ID_XORI;
          3'd5: w_id = w_f7b ? ID_SRAI : ID_SRLI;
          3'd6: w_id = ID_ORI;
          default: w_id = ID_ANDI;
        endcase
        w_imm = (w_f3 == 3'd1 || w_f3 == 3'd5) ? w_imm_sh : w_imm_i;
        w_rs  = 1'b1;
      end
      7'b0110011: begin
        case (w_f3)
          3'd0: w_id = w_f7b ? ID_SUB : ID_ADD;
          3'd1: w_id = ID_SLL;
          3'd2: w_id = ID_SLT;
          3'd3: w_id = ID_SLTU;
          3'd4: w_id = ID_XOR;
          3'd5: w_id = w_f7b ? ID_SRA : ID_SRL;
          3'd6: w_id = ID_OR;
          default: w_id = ID_AND;
        endcase
        w_rs2 = w_ins[24:20];
        w_rs  = 1'b1;
      end
      default: w_id = ID_NONE;
    endcase
    // Illegal words dispatch as a bare ROB NOP: every routed field is cleared.
    w_ill = (w_id == ID_NONE);
    if (w_ill) begin
      w_rd  = '0;
      w_rs1 = '0;
      w_rs2 = '0;
      w_imm = '0;
      w_lsb = 1'b0;
      w_rs  = 1'b0;
    end
  end

  assign w_pop = rdy && !flush && !w_empty && !rob_full
                 && !(w_lsb && lsb_full) && !(w_rs && rs_full);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_tail]  <= in_instr;
      r_isjump[r_tail] <= in_isjump;
      r_wpc[r_tail]    <= in_wrong_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_out_valid    <= 1'b0;
      r_rd           <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_opcode_id    <= '0;
      r_imm          <= '0;
      r_to_lsb       <= 1'b0;
      r_to_rs        <= 1'b0;
      r_illegal      <= 1'b0;
      r_out_isjump   <= 1'b0;
      r_out_wrong_pc <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      // The output stage always reloads, so a dispatch is never repeated while rdy is low.
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_rd           <= w_rd;
        r_rs1          <= w_rs1;
        r_rs2          <= w_rs2;
        r_opcode_id    <= w_id;
        r_imm          <= w_imm;
        r_to_lsb       <= w_lsb;
        r_to_rs        <= w_rs;
        r_illegal      <= w_ill;
        r_out_isjump   <= r_isjump[r_head];
        r_out_wrong_pc <= r_wpc[r_head];
      end else begin
        r_rd           <= '0;
        r_rs1          <= '0;
        r_rs2          <= '0;
        r_opcode_id    <= '0;
        r_imm          <= '0;
        r_to_lsb       <= 1'b0;
        r_to_rs        <= 1'b0;
        r_illegal      <= 1'b0;
        r_out_isjump   <= 1'b0;
        r_out_wrong_pc <= '0;
      end
    end
  end

  assign count        = r_count;
  assign out_valid    = r_out_valid;
  assign rd           = r_rd;
  assign reg_rs1      = r_rs1;
  assign reg_rs2      = r_rs2;
  assign opcode_id    = r_opcode_id;
  assign imm          = r_imm;
  assign to_lsb       = r_to_lsb;
  assign to_rs        = r_to_rs;
  assign illegal      = r_illegal;
  assign out_isjump   = r_out_isjump;
  assign out_wrong_pc = r_out_wrong_pc;

  assign rs1_ready = rf_rs1_ready | rob_rs1_ready;
  assign rs2_ready = rf_rs2_ready | rob_rs2_ready;
  assign reg1      = rf_rs1_ready ? rf_reg1 : rob_reg1;
  assign reg2      = rf_rs2_ready ? rf_reg2 : rob_reg2;

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Parameters
REQ-001 DEPTH, 4, instruction-buffer entries; power of two, minimum 2.
REQ-002 CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Interface
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rdy  in  1  global enable; when low, no push, no pop and no state change (except rst/flush).
REQ-006 flush  in  1  branch-mispredict flush (jump_wrong).
REQ-007 in_valid / in_ready  in / out  1 / 1  fetch handshake.
REQ-008 in_instr  in  32  fetched RV32I instruction word.
REQ-009 in_isjump  in  1  predictor decision: 1 = took +imm, 0 = took +4.
REQ-010 in_wrong_pc  in  32  recovery PC if the prediction is wrong.
REQ-011 rob_full, lsb_full, rs_full  in  1 each  downstream back-pressure.
REQ-012 reg_rs1, reg_rs2  out  5  register-file/ROB lookup addresses.
REQ-013 rf_rs1_ready, rf_rs2_ready, rf_reg1, rf_reg2  in  1,1,32,32  register-file lookup results.
REQ-014 rob_rs1_ready, rob_rs2_ready, rob_reg1, rob_reg2  in  1,1,32,32  ROB forwarding results.
REQ-015 out_valid  out  1  one-cycle dispatch pulse.
REQ-016 rd  out  5  destination register.
REQ-017 opcode_id  out  6  shared instruction-ID code.
REQ-018 imm  out  32  decoded immediate.
REQ-019 rs1_ready, rs2_ready, reg1, reg2  out  1,1,32,32  resolved operands.
REQ-020 to_lsb, to_rs, illegal  out  1 each  routing and illegal-instruction flags.
REQ-021 out_isjump, out_wrong_pc  out  1, 32  prediction info forwarded to the ROB.
REQ-022 count  out  CNT_W  current FIFO occupancy.

Function
REQ-023 FIFO: circular buffer of {instr, isjump, wrong_pc}; head/tail pointers wrap modulo DEPTH.
REQ-024 in_ready = rdy && (count != DEPTH) && !flush.
REQ-025 Push happens when in_valid && in_ready; a full FIFO never accepts, even if a pop occurs in the same cycle.
REQ-026 Head class: load/store -> LSB; OP-IMM/OP/BRANCH/JALR -> RS; LUI/AUIPC/JAL/illegal -> ROB only.
REQ-027 Pop condition: rdy && !flush && count>0 && !rob_full && !(head is LSB-class && lsb_full) && !(head is RS-class && rs_full).
REQ-028 Simultaneous push and pop: count is unchanged and both pointers advance.
REQ-029 On pop, the decode of the head is registered into the output stage, out_valid=1 for exactly one cycle; otherwise out_valid=0 next cycle and the other output fields are zeroed.
REQ-030 Minimum latency: push at edge N, pop at edge N+1, out_valid high during cycle N+1..N+2.
REQ-031 Field rules:
- rd=0 for BRANCH and STORE.
- reg_rs1=0 for LUI/AUIPC/JAL.
- reg_rs2=instr[24:20] only for BRANCH/STORE/OP, else 0.
- reg_rs1 and reg_rs2 are zero when out_valid=0.
REQ-032 Immediates:
- I-type: sign-extended [31:20].
- Shift-imm: zero-extended shamt [24:20].
- S-type: sign-extended {[31:25],[11:7]}.
- B-type: sign-extended {[31],[7],[30:25],[11:8],0}.
- U-type: {[31:12],12'b0}.
- J-type: sign-extended {[31],[19:12],[20],[30:21],0}.
- OP: imm=0.
REQ-033 opcode_id covers the full RV32I ALU/branch/load/store/jump set; funct7[5] selects SUB/SRA/SRAI.
REQ-034 Unknown opcode or funct3: illegal=1, opcode_id=0, to_lsb=to_rs=0, rd=0; the instruction still dispatches so the ROB can retire it as a NOP.
REQ-035 Operand resolution is combinational: rsX_ready = rf_rsX_ready | rob_rsX_ready; regX = rf_regX if rf_rsX_ready, else rob_regX.
REQ-036 flush (acts regardless of rdy): next edge sets count=0, head=tail=0 and out_valid=0; a push or pop in the flush cycle is discarded.

Reset
REQ-037 rst has priority over flush and rdy: count=0, pointers=0, out_valid=0, all registered outputs 0, in_ready=0 during reset.
REQ-038 Reset mid-operation discards all buffered instructions; no dispatch occurs in the cycle after reset deasserts.

Verification
REQ-039 Push ADDI x5,x0,7 (0x00700293), no back-pressure -> out_valid one cycle later; rd=5, imm=7, to_rs=1, reg_rs1=0.
REQ-040 DEPTH=4, rob_full=1, push 5 words -> count=4, in_ready=0, 5th word not accepted; release rob_full -> 4 in-order pulses.
REQ-041 Head LW, lsb_full=1, rs_full=0 -> no pop; head ADD with lsb_full=1 -> pops, to_rs=1.
REQ-042 Four entries buffered, flush with in_valid=1 -> count=0 next cycle, no out_valid, flushed-cycle word lost.
REQ-043 Push 0xFFFFFFFF -> illegal=1, opcode_id=0, to_lsb=to_rs=0, out_valid=1.
REQ-044 Push BEQ with offset -4 and JAL with offset +2048 -> imm=0xFFFFFFFC and 0x00000800; BEQ rd=0; out_isjump/out_wrong_pc match input.
